// File: rtl/tp_mem_stream_reader.sv
// tp_mem_stream_reader
//   Read-side burst controller for a 1r1w two-port memory. A command (start
//   address, length-1) is accepted, then one read is issued per cycle on the
//   memory read port. The memory's one-cycle registered read latency is absorbed,
//   and the words come back as a valid/ready stream through a 2-entry buffer.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
//   both high. A producer holds valid and its payload stable until that edge.
//   Ready may depend on valid, but valid never depends on ready.
//   This applies to both cmd_* and out_*.
//
// Optional feature macro: TP_MEM_RD_COLLISION_AVOID_EN
//   When defined, a read is withheld while the write-port snoop (wr_we, wr_addr)
//   targets the address about to be read. When undefined, the snoop is ignored.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   cmd_valid/ready, cmd_addr, cmd_len   burst command (cmd_len = words - 1)
//   mem_re, mem_raddr, mem_rdata         memory read port (data one cycle after mem_re)
//   wr_we, wr_addr                       memory write-port snoop
//   out_valid/ready, out_data, out_last  output stream, out_last on final beat
//   busy                                 high from command accept until the last beat transfers
//   dbg_state                            current FSM state (0 IDLE, 1 READ, 2 DRAIN)
module tp_mem_stream_reader #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              wr_we,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W:0]     rem;            // reads still to issue; one extra bit for a full-memory burst
  logic                inflight;       // a read was issued last cycle, its data is on mem_rdata now
  logic                inflight_last;  // that read was the final word of the burst
  logic [1:0]          count;          // buffer occupancy
  logic [DATA_W-1:0]   d0, d1;         // d0 is the head entry and drives out_data
  logic                l0, l1;
  logic                pop;
  logic                wr_block;
  logic [2:0]          credit_used;

`ifdef TP_MEM_RD_COLLISION_AVOID_EN
  assign wr_block = wr_we && (wr_addr == addr);
`else
  logic unused_wr;
  assign unused_wr = ^{wr_we, wr_addr};
  assign wr_block  = 1'b0;
`endif

  assign pop         = out_valid && out_ready;
  // Slots that will be occupied after this edge if no new read is issued. The
  // pop in this cycle frees a slot, so one beat per cycle can be sustained.
  assign credit_used = 3'(count) + 3'(inflight) - 3'(pop);

  assign cmd_ready = (state == IDLE) && !rst;
  assign mem_re    = !rst && (state == READ) && (rem != '0) &&
                     (credit_used < 3'd2) && !wr_block;
  assign mem_raddr = addr;
  assign out_valid = (count != 2'd0);
  assign out_data  = d0;
  assign out_last  = l0;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr          <= '0;
      rem           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      count         <= 2'd0;
      d0            <= '0;
      d1            <= '0;
      l0            <= 1'b0;
      l1            <= 1'b0;
    end else begin
      inflight      <= mem_re;
      inflight_last <= mem_re && (rem == REM_ONE);
      if (mem_re) begin
        addr <= addr + ADDR_W'(1);   // wraps silently at the top of memory
        rem  <= rem - REM_ONE;
      end

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state <= READ;
            addr  <= cmd_addr;
            rem   <= {1'b0, cmd_len} + REM_ONE;
          end
        end
        READ: begin
          if (mem_re && (rem == REM_ONE)) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && out_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Buffer update: push is the returning read data, pop is the stream transfer.
      case ({inflight, pop})
        2'b10: begin
          if (count == 2'd0) begin
            d0 <= mem_rdata;
            l0 <= inflight_last;
          end else begin
            d1 <= mem_rdata;
            l1 <= inflight_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          d0    <= d1;
          // Clear the head flag when the buffer empties so out_last never shows a stale 1.
          l0    <= (count == 2'd2) ? l1 : 1'b0;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            d0 <= mem_rdata;
            l0 <= inflight_last;
          end else begin
            d0 <= d1;
            l0 <= l1;
            d1 <= mem_rdata;
            l1 <= inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tp_mem_stream_reader.sv
// Testbench for tp_mem_stream_reader: memory model, directed and randomized
// bursts, and a scoreboard holding the expected {last, data} beats.
`timescale 1ns/1ps
module tb_tp_mem_stream_reader;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 8;
  localparam int W      = DATA_W + 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              cmd_valid, cmd_ready;
  logic [ADDR_W-1:0] cmd_addr, cmd_len;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic              wr_we;
  logic [ADDR_W-1:0] wr_addr;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last, busy;
  logic [1:0]        dbg_state;

  tp_mem_stream_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .wr_we(wr_we), .wr_addr(wr_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .dbg_state(dbg_state)
  );

  // memory model: registered read, one cycle latency
  logic [DATA_W-1:0] mem [256];
  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_raddr];

  // scoreboard
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int issued, popped, beats;
  int hs_cyc, first_valid_cyc, first_pop_cyc, last_pop_cyc;
  bit hs_seen, prev_last_pop;
  logic rdy_after_last;
  logic s_mem_re, s_out_valid, s_busy, s_cmd_ready, s_out_last;
  logic [ADDR_W-1:0] s_raddr;
  logic [DATA_W-1:0] s_out_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs were set after the last negedge; sample 1ns later,
  // update the model and scoreboard, then advance to the next negedge.
  task automatic step();
    logic [W-1:0] e;
    #1;
    s_mem_re = mem_re; s_out_valid = out_valid; s_busy = busy; s_cmd_ready = cmd_ready;
    s_out_last = out_last; s_raddr = mem_raddr; s_out_data = out_data;
    if (rst) begin
      exp_q.delete();
      issued = 0; popped = 0; prev_last_pop = 0;
    end else begin
      if (prev_last_pop) rdy_after_last = cmd_ready;
      prev_last_pop = 0;
      if (cmd_valid && cmd_ready) begin
        hs_seen = 1; hs_cyc = cyc;
        for (int i = 0; i <= int'(cmd_len); i++)
          exp_q.push_back({(i == int'(cmd_len)), mem[(int'(cmd_addr) + i) % 256]});
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("beat_data", out_data, e[DATA_W-1:0]);
          check("beat_last", 64'(out_last), 64'(e[DATA_W]));
        end
        popped++; beats++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        if (out_last) prev_last_pop = 1;
      end
      if (mem_re) issued++;
      check("outstanding_le_2", 64'((issued - popped) <= 2), 64'd1);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic send_cmd(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] l);
    int n = 0;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
    hs_seen = 0; first_valid_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
    beats = 0; rdy_after_last = 1'b0;
    while (!hs_seen && n < 20) begin step(); n++; end
    cmd_valid = 1'b0;
    if (!hs_seen) check("cmd_timeout", 64'd0, 64'd1);
  endtask

  // mode 0: out_ready always 1; mode 1: out_ready random 50%
  task automatic run_idle(input int mode, input int budget);
    int n = 0;
    bit done = 0;
    while (!done) begin
      out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      step();
      n++;
      if (!s_busy && exp_q.size() == 0) done = 1;
      else if (n >= budget) begin check("idle_timeout", 64'd0, 64'd1); done = 1; end
    end
    out_ready = 1'b1;
    check("leftover_beats", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] ra;
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_we = 1'b0; wr_addr = '0; out_ready = 1'b1;
    issued = 0; popped = 0; beats = 0; prev_last_pop = 0;
    first_valid_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1; hs_cyc = 0; hs_seen = 0;
    @(negedge clk);

    // reset state
    step();
    step();
    check("rst_cmd_ready_low", 64'(s_cmd_ready), 64'd0);
    rst = 1'b0;
    step();
    check("rst_out_valid", 64'(s_out_valid), 64'd0);
    check("rst_mem_re", 64'(s_mem_re), 64'd0);
    check("rst_busy", 64'(s_busy), 64'd0);
    check("rst_out_last", 64'(s_out_last), 64'd0);
    check("rst_out_data", s_out_data, 64'd0);
    check("rst_mem_raddr", 64'(s_raddr), 64'd0);
    check("rst_cmd_ready_high", 64'(s_cmd_ready), 64'd1);

    // single-word burst: latency and command re-acceptance
    send_cmd(8'h10, 8'd0);
    run_idle(0, 50);
    check("t1_beats", 64'(beats), 64'd1);
    check("t1_latency", 64'(first_valid_cyc - hs_cyc), 64'd3);
    check("t1_cmd_ready_after_last", 64'(rdy_after_last), 64'd1);

    // address wrap
    send_cmd(8'hFE, 8'd3);
    run_idle(0, 50);
    check("t2_beats", 64'(beats), 64'd4);

    // full-memory burst, no bubbles
    send_cmd(8'h00, 8'hFF);
    run_idle(0, 400);
    check("t3_beats", 64'(beats), 64'd256);
    check("t3_no_bubble", 64'(last_pop_cyc - first_pop_cyc), 64'd255);

    // random backpressure
    send_cmd(8'($urandom), 8'd31);
    run_idle(1, 400);
    check("t4_beats", 64'(beats), 64'd32);
    for (int k = 0; k < 4; k++) begin
      ra = 8'($urandom);
      send_cmd(ra, 8'($urandom_range(0, 40)));
      run_idle(1, 400);
    end

    // reset mid-burst
    send_cmd(8'($urandom), 8'd15);
    begin
      int n = 0;
      while (beats < 5 && n < 40) begin step(); n++; end
      check("t5_five_beats", 64'(beats), 64'd5);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("t5_out_valid", 64'(s_out_valid), 64'd0);
    check("t5_mem_re", 64'(s_mem_re), 64'd0);
    check("t5_busy", 64'(s_busy), 64'd0);
    send_cmd(8'h40, 8'd1);
    run_idle(0, 50);
    check("t5_beats", 64'(beats), 64'd2);

    // write snoop on the next read address for two cycles
    send_cmd(8'h80, 8'd3);
    wr_we = 1'b1; wr_addr = mem_raddr;
    step();
    check("t6_raddr0", 64'(s_raddr), 64'h80);
`ifdef TP_MEM_RD_COLLISION_AVOID_EN
    check("t6_re0", 64'(s_mem_re), 64'd0);
`else
    check("t6_re0", 64'(s_mem_re), 64'd1);
`endif
    wr_addr = mem_raddr;
    step();
`ifdef TP_MEM_RD_COLLISION_AVOID_EN
    check("t6_re1", 64'(s_mem_re), 64'd0);
    check("t6_raddr1", 64'(s_raddr), 64'h80);
`else
    check("t6_re1", 64'(s_mem_re), 64'd1);
    check("t6_raddr1", 64'(s_raddr), 64'h81);
`endif
    wr_we = 1'b0;
    step();
    check("t6_re2", 64'(s_mem_re), 64'd1);
`ifdef TP_MEM_RD_COLLISION_AVOID_EN
    check("t6_raddr2", 64'(s_raddr), 64'h80);
`else
    check("t6_raddr2", 64'(s_raddr), 64'h82);
`endif
    run_idle(0, 50);
    check("t6_beats", 64'(beats), 64'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
